// File: rtl/h_frame_sched_pkg.sv
// rtl/h_frame_sched_pkg.sv - shared types and constants for the frame scheduler
package h_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_SINK,
    S_LOAD,
    S_RUN,
    S_GAP,
    S_FINISH
  } state_t;

  // Nominal datapath burst: 16 symbols x 8 cycles.
  localparam int BURST_LEN = 128;

  // Default cycles allowed in RUN before the watchdog trips.
  localparam int WDOG_DEFAULT = 255;

endpackage

// File: rtl/h_frame_sched_if.sv
// rtl/h_frame_sched_if.sv - control/datapath bundle between top control and the scheduler
interface h_frame_sched_if #(
  parameter int FRAME_W = 8,
  parameter int GAP_W   = 4
);
  logic               start;
  logic [FRAME_W-1:0] num_frames;
  logic [GAP_W-1:0]   gap_cycles;
  logic               sink_ready;
  logic               abort;
  logic               tx_en;
  logic               load_h;
  logic               dp_rst;
  logic               busy;
  logic [FRAME_W-1:0] frame_idx;
  logic               done;
  logic               err;

  // Controller / datapath side driving the scheduler.
  modport master (
    output start, num_frames, gap_cycles, sink_ready, abort, tx_en,
    input  load_h, dp_rst, busy, frame_idx, done, err
  );

  // Scheduler side.
  modport slave (
    input  start, num_frames, gap_cycles, sink_ready, abort, tx_en,
    output load_h, dp_rst, busy, frame_idx, done, err
  );
endinterface

// File: rtl/h_frame_sched_gap_timer.sv
// rtl/h_frame_sched_gap_timer.sv - inter-frame gap down-counter
module h_gap_timer #(
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [GAP_W-1:0] load_val_i,
  input  logic             en_i,
  output logic             expire_o
);
  logic [GAP_W-1:0] cnt_q, cnt_d;

  // Load on entry to the gap, then count down while the gap state is active.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && cnt_q != '0) begin
      cnt_d = cnt_q - GAP_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Last gap cycle is the one where the count has reached 1.
  assign expire_o = en_i && (cnt_q == GAP_W'(1));

endmodule

// File: rtl/h_frame_sched.sv
// rtl/h_frame_sched.sv - frame-level load/gap/watchdog scheduler for the H/S read datapath
module h_frame_sched
  import h_sched_pkg::*;
#(
  parameter int FRAME_W = 8,
  parameter int GAP_W   = 4,
  parameter int WDOG    = WDOG_DEFAULT
) (
  input logic             clk,
  input logic             rst,
  h_frame_sched_if.slave  bus
);
  localparam int WD_W = $clog2(WDOG + 1);

  state_t             state_q, state_d;
  logic               seen_q, seen_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [FRAME_W-1:0] num_q, num_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [FRAME_W-1:0] idx_q, idx_d;
  logic               err_q, err_d;
  logic               load_h_q, load_h_d;
  logic               dp_rst_q, dp_rst_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               gap_load, gap_expire;
  logic               frame_end, last_frame, wd_hit;

  h_gap_timer #(.GAP_W(GAP_W)) u_gap (
    .clk        (clk),
    .rst        (rst),
    .load_i     (gap_load),
    .load_val_i (gap_q),
    .en_i       (state_q == S_GAP),
    .expire_o   (gap_expire)
  );

  assign frame_end  = seen_q && !bus.tx_en;
  assign last_frame = (idx_q == num_q - FRAME_W'(1));
  assign wd_hit     = (wd_q == WD_W'(WDOG - 1));

  // Next-state and registered-output decode; abort overrides everything below it.
  always_comb begin
    state_d  = state_q;
    seen_d   = seen_q;
    wd_d     = wd_q;
    num_d    = num_q;
    gap_d    = gap_q;
    idx_d    = idx_q;
    err_d    = err_q;
    dp_rst_d = 1'b0;
    done_d   = 1'b0;
    gap_load = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          err_d = 1'b0;
          if (bus.num_frames != '0) begin
            num_d   = bus.num_frames;
            gap_d   = bus.gap_cycles;
            idx_d   = '0;
            state_d = S_WAIT_SINK;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      S_WAIT_SINK: if (bus.sink_ready) state_d = S_LOAD;
      S_LOAD: begin
        seen_d  = 1'b0;
        wd_d    = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        seen_d = seen_q | bus.tx_en;
        wd_d   = wd_q + WD_W'(1);
        if (wd_hit) begin
          err_d    = 1'b1;
          dp_rst_d = 1'b1;
          state_d  = S_IDLE;
        end else if (frame_end) begin
          if (last_frame) begin
            state_d = S_FINISH;
          end else begin
            idx_d = idx_q + FRAME_W'(1);
            if (gap_q != '0) begin
              gap_load = 1'b1;
              state_d  = S_GAP;
            end else begin
              state_d = S_WAIT_SINK;
            end
          end
        end
      end
      S_GAP:    if (gap_expire) state_d = S_WAIT_SINK;
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (bus.abort && state_q != S_IDLE) begin
      state_d  = S_IDLE;
      dp_rst_d = 1'b1;
      err_d    = err_q;
      idx_d    = idx_q;
      gap_load = 1'b0;
    end

    // FINISH is a one-cycle completion marker, so busy is already low while done pulses.
    load_h_d = (state_d == S_LOAD);
    busy_d   = (state_d inside {S_WAIT_SINK, S_LOAD, S_RUN, S_GAP});
    done_d   = done_d || (state_d == S_FINISH);
  end

  // State, configuration and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      seen_q   <= 1'b0;
      wd_q     <= '0;
      num_q    <= '0;
      gap_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      load_h_q <= 1'b0;
      dp_rst_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seen_q   <= seen_d;
      wd_q     <= wd_d;
      num_q    <= num_d;
      gap_q    <= gap_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      load_h_q <= load_h_d;
      dp_rst_q <= dp_rst_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.load_h    = load_h_q;
  assign bus.dp_rst    = dp_rst_q;
  assign bus.busy      = busy_q;
  assign bus.frame_idx = idx_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_h_frame_sched.sv
// tb/tb_h_frame_sched.sv - directed self-checking bench for h_frame_sched
module tb_h_frame_sched;
  import h_sched_pkg::*;

  localparam int WDOG_TB = 255;

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0;
  int   n_fail   = 0;

  h_frame_sched_if #(.FRAME_W(8), .GAP_W(4)) bus ();

  h_frame_sched #(.FRAME_W(8), .GAP_W(4), .WDOG(WDOG_TB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start for one cycle; returns in the cycle after start.
  task automatic go(input int num, input int gap);
    bus.start      = 1'b1;
    bus.num_frames = 8'(num);
    bus.gap_cycles = 4'(gap);
    cyc();
    bus.start = 1'b0;
  endtask

  // Step dly cycles; load_h must appear only in the last one.
  task automatic expect_load(input int dly, input int idx, input string tag);
    int spur = 0;
    for (int k = 1; k < dly; k++) begin
      cyc();
      if (bus.load_h) spur++;
    end
    cyc();
    chk({tag, "_early"}, spur, 0);
    chk({tag, "_load_h"}, bus.load_h, 1);
    chk({tag, "_idx"}, bus.frame_idx, idx);
    chk({tag, "_busy"}, bus.busy, 1);
  endtask

  // Datapath burst model: tx_en high for n cycles after load, then low (frame-end cycle).
  task automatic burst(input int n, input string tag);
    int spur = 0;
    for (int k = 0; k < n; k++) begin
      cyc();
      bus.tx_en = 1'b1;
      if (bus.load_h || bus.dp_rst || bus.done) spur++;
    end
    cyc();
    bus.tx_en = 1'b0;
    chk({tag, "_spurious"}, spur, 0);
  endtask

  initial begin
    int spur;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.num_frames = '0;
    bus.gap_cycles = '0;
    bus.sink_ready = 1'b0;
    bus.abort      = 1'b0;
    bus.tx_en      = 1'b0;
    repeat (3) cyc();
    chk("rst_load_h", bus.load_h, 0);
    chk("rst_dp_rst", bus.dp_rst, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_idx", bus.frame_idx, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b0;
    cyc();

    // Three frames, no gap: loads at t+2, t+133, t+264; done after last frame end.
    bus.sink_ready = 1'b1;
    go(3, 0);
    chk("a_busy_ws", bus.busy, 1);
    expect_load(1, 0, "a_f0");
    burst(BURST_LEN, "a_f0");
    expect_load(2, 1, "a_f1");
    burst(BURST_LEN, "a_f1");
    expect_load(2, 2, "a_f2");
    burst(BURST_LEN, "a_f2");
    cyc();
    chk("a_done", bus.done, 1);
    chk("a_busy_fin", bus.busy, 0);
    chk("a_idx_hold", bus.frame_idx, 2);
    cyc();
    chk("a_done_pulse", bus.done, 0);
    chk("a_idx_hold2", bus.frame_idx, 2);

    // Two frames with a 5-cycle gap: second load slips by exactly 5.
    go(2, 5);
    expect_load(1, 0, "b_f0");
    burst(BURST_LEN, "b_f0");
    expect_load(7, 1, "b_f1");
    burst(BURST_LEN, "b_f1");
    cyc();
    chk("b_done", bus.done, 1);

    // sink_ready low for 20 cycles after the first frame.
    cyc();
    go(2, 0);
    expect_load(1, 0, "c_f0");
    bus.sink_ready = 1'b0;
    burst(BURST_LEN, "c_f0");
    spur = 0;
    for (int k = 0; k < 21; k++) begin
      cyc();
      if (bus.load_h) spur++;
    end
    chk("c_hold_no_load", spur, 0);
    chk("c_hold_busy", bus.busy, 1);
    bus.sink_ready = 1'b1;
    expect_load(1, 1, "c_f1");
    burst(BURST_LEN, "c_f1");
    cyc();
    chk("c_done", bus.done, 1);

    // Abort 40 cycles into frame 1.
    cyc();
    go(3, 0);
    expect_load(1, 0, "d_f0");
    burst(BURST_LEN, "d_f0");
    expect_load(2, 1, "d_f1");
    for (int k = 0; k < 40; k++) begin
      cyc();
      bus.tx_en = 1'b1;
    end
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    bus.tx_en = 1'b0;
    chk("d_dp_rst", bus.dp_rst, 1);
    chk("d_busy", bus.busy, 0);
    chk("d_done", bus.done, 0);
    chk("d_err", bus.err, 0);
    cyc();
    chk("d_dp_rst_pulse", bus.dp_rst, 0);
    chk("d_done_after", bus.done, 0);
    chk("d_load_after", bus.load_h, 0);

    // Abort while idle is ignored.
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;
    chk("idle_abort_dp_rst", bus.dp_rst, 0);

    // Watchdog: tx_en never rises after load.
    go(1, 0);
    expect_load(1, 0, "e_f0");
    spur = 0;
    for (int k = 0; k < WDOG_TB; k++) begin
      cyc();
      if (bus.dp_rst || bus.err) spur++;
    end
    chk("e_early_trip", spur, 0);
    cyc();
    chk("e_err", bus.err, 1);
    chk("e_dp_rst", bus.dp_rst, 1);
    chk("e_busy", bus.busy, 0);
    chk("e_done", bus.done, 0);
    cyc();
    chk("e_dp_rst_pulse", bus.dp_rst, 0);
    chk("e_err_sticky", bus.err, 1);

    // Zero-frame start: done next cycle, no load, err cleared.
    go(0, 0);
    chk("f_done", bus.done, 1);
    chk("f_err_clr", bus.err, 0);
    chk("f_busy", bus.busy, 0);
    chk("f_load_h", bus.load_h, 0);
    cyc();
    chk("f_done_pulse", bus.done, 0);
    chk("f_load_h2", bus.load_h, 0);

    // Reset mid-RUN of frame 1, with a simultaneous start that must be ignored.
    go(2, 0);
    expect_load(1, 0, "g_f0");
    burst(BURST_LEN, "g_f0");
    expect_load(2, 1, "g_f1");
    for (int k = 0; k < 10; k++) begin
      cyc();
      bus.tx_en = 1'b1;
    end
    rst            = 1'b1;
    bus.start      = 1'b1;
    bus.num_frames = 8'd4;
    cyc();
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.tx_en = 1'b0;
    chk("g_rst_idx", bus.frame_idx, 0);
    chk("g_rst_busy", bus.busy, 0);
    chk("g_rst_load_h", bus.load_h, 0);
    chk("g_rst_dp_rst", bus.dp_rst, 0);
    chk("g_rst_done", bus.done, 0);
    chk("g_rst_err", bus.err, 0);
    cyc();
    chk("g_start_ignored", bus.busy, 0);
    cyc();
    chk("g_no_load", bus.load_h, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
